dcdc_pad_sequencer: RTL and testbench
=====================================

Name: dcdc_pad_sequencer

Overview:
Controller for the on-die DC-DC converter test interface exposed through the pad frame (control_1, control_2, clk_ext, sel_clk, SM_ext, sel_SM, PFM_out).
- Sequences power-up and power-down of the converter.
- Generates the external converter clock.
- Issues state-machine step pulses.
- Measures PFM pulse density.
- Sits between the host register file (config/commands) and the pad-side dcdc signals.

Parameters:
- DIV_W, 8, width of the clock-divider setting.
- SETTLE_W, 16, width of the settle-delay counter.
- WIN_W, 16, width of the PFM measurement window.
- CNT_W, 16, width of the PFM edge counter (saturating).
- SM_PULSE, 4, SM_ext pulse length in clk_i cycles (≥1).

Ports:
- clk_i in 1: system clock.
- rst_i in 1: synchronous reset, active-high.
- start_i in 1: power-up request (level, sampled each cycle).
- stop_i in 1: power-down request.
- clk_div_i in DIV_W: clk_ext half-period minus 1.
- settle_i in SETTLE_W: settle delay per phase, in cycles.
- ext_clk_sel_i in 1: use external clock (drives sel_clk).
- ext_sm_sel_i in 1: use external SM stepping (drives sel_SM).
- mode_i in 1: converter mode (drives control_2).
- sm_step_i in 1: request one SM_ext pulse.
- pfm_window_i in WIN_W: measurement window length in cycles.
- pfm_i in 1: PFM_out from pad, asynchronous.
- dcdc_control_1_o out 1: converter enable.
- dcdc_control_2_o out 1: converter mode.
- dcdc_clk_ext_o out 1: generated external clock.
- dcdc_sel_clk_o out 1: clock source select.
- dcdc_SM_ext_o out 1: SM step pulse.
- dcdc_sel_SM_o out 1: SM source select.
- state_o out 3: current FSM state encoding.
- busy_o out 1: high in any state except OFF.
- pfm_count_o out CNT_W: last completed window edge count.
- pfm_valid_o out 1: one-cycle strobe when pfm_count_o updates.

Behaviour:
- Reset: all outputs 0, FSM=OFF, all counters 0, latched config 0. rst_i asserted in any state returns to OFF on the next edge, with no shutdown sequence.
- Config latch: clk_div_i, settle_i, ext_clk_sel_i, ext_sm_sel_i, mode_i and pfm_window_i are latched only on the OFF→CONFIG transition. Changes to them at any other time are ignored.
- FSM states: OFF=0, CONFIG=1, CLK_START=2, ENABLE=3, RUN=4, SHUTDOWN=5.
- OFF:
  - All dcdc outputs 0.
  - start_i=1 and stop_i=0 → CONFIG, settle counter loaded with the latched settle value.
  - start_i and stop_i both high → stay OFF.
- CONFIG:
  - sel_clk, sel_SM and control_2 take their latched values on the first CONFIG cycle.
  - On settle counter expiry → CLK_START.
- CLK_START:
  - Divider runs when sel_clk=1; otherwise clk_ext stays 0.
  - On settle expiry → ENABLE.
- ENABLE:
  - control_1=1 from the first ENABLE cycle.
  - On settle expiry → RUN.
- Settle counter:
  - Reloaded on every phase entry.
  - A settle value of 0 means the phase lasts exactly 1 cycle; N means N+1 cycles.
- stop_i in CONFIG, CLK_START, ENABLE or RUN → SHUTDOWN on the next edge; stop_i takes priority over settle expiry.
- start_i outside OFF is ignored.
- SHUTDOWN:
  - control_1=0 on the first cycle.
  - clk_ext keeps running for the settle duration, then → OFF.
  - On OFF entry, clk_ext, sel_clk, sel_SM and control_2 all return to 0.
- Divider:
  - clk_ext toggles every (clk_div+1) cycles, giving a period of 2·(clk_div+1). clk_div=0 gives clk_i/2.
  - clk_ext starts low on CLK_START entry.
  - clk_ext is forced to 0 in OFF.
- SM_ext:
  - In RUN with sel_SM=1, sm_step_i=1 while idle produces a pulse high for exactly SM_PULSE cycles, starting the cycle after the request.
  - Requests during an active pulse, outside RUN, or with sel_SM=0 are dropped.
  - Leaving RUN aborts the pulse, forcing SM_ext to 0.
- PFM monitor:
  - pfm_i passes through a 2-FF synchronizer, then rising-edge detection (3rd flop).
  - Latency from pad edge to count is 3 cycles.
  - Active only in RUN. The window counter counts max(pfm_window,1) cycles.
  - On the final window cycle: pfm_count_o ← edge count, including an edge detected in that same cycle; pfm_valid_o=1 for 1 cycle; edge count restarts at 0.
  - The edge counter saturates at 2^CNT_W−1.
  - Leaving RUN clears the window and edge counters; pfm_count_o holds its last value.
  - Synchronizer flops run in all states.

Decomposition:
- Package dcdc_seq_pkg: state_e enum (3-bit encodings above) and SM_PULSE default constant.
- One natural sub-module: pfm_edge_counter (synchronizer, edge detect, window counter, saturating count, valid strobe).
- Divider and FSM stay in the top module.

Test Plan:
- Power-up sequencing:
  - Stimulus: settle=3, div=1, ext_clk_sel=1, mode=1, start pulse.
  - Required: CONFIG 4 cycles → CLK_START 4 cycles → ENABLE 4 cycles → RUN; control_1 rises at ENABLE entry; clk_ext period 4 cycles; busy_o=1.
- Early stop:
  - Stimulus: stop_i during CLK_START (settle=10).
  - Required: SHUTDOWN next cycle, control_1 stays 0, 11 cycles later OFF with every dcdc output 0.
- SM stepping:
  - Stimulus: RUN, sel_SM=1, SM_PULSE=4; sm_step_i at cycles t and t+2.
  - Required: exactly one 4-cycle SM_ext pulse from t+1 (second request dropped). With sel_SM=0, no pulse.
- PFM measurement:
  - Stimulus: window=100; pfm_i square wave, period 10 cycles.
  - Required: pfm_valid_o every 100 cycles, pfm_count_o=10. Stop mid-window → no strobe, count held.
- Saturation:
  - Stimulus: CNT_W=4, window=100, pfm period 4 cycles.
  - Required: pfm_count_o=15.
- Mid-sequence reset and start/stop collision:
  - Stimulus: rst_i in RUN.
  - Required: next cycle all outputs 0, state_o=0. Then start_i=stop_i=1 in OFF → remains OFF.

Source files
------------

// File: rtl/dcdc_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : dcdc_seq_pkg                                           |
// | Description : Shared types and constants for the DC-DC pad           |
// |               sequencer (FSM state encoding, SM pulse default).      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package dcdc_seq_pkg;

   // Encodings are visible on state_o, so they are fixed explicitly.
   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_CONFIG    = 3'd1,
      ST_CLK_START = 3'd2,
      ST_ENABLE    = 3'd3,
      ST_RUN       = 3'd4,
      ST_SHUTDOWN  = 3'd5
   } state_e;

   localparam int SM_PULSE_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/pfm_edge_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pfm_edge_counter                                       |
// | Description : Counts rising edges of the asynchronous PFM_out pad    |
// |               signal over a programmable window of clk_i cycles and  |
// |               publishes the result with a one-cycle valid strobe.    |
// | Revision    : 1.0  initial release                                   |
// |                                                                      |
// | Ports       : clk_i      system clock                                |
// |               rst_i      synchronous active-high reset               |
// |               enable_i   measurement active (converter in RUN)       |
// |               window_i   window length in cycles (0 treated as 1)    |
// |               pfm_i      asynchronous PFM_out from the pad           |
// |               count_o    edge count of the last completed window     |
// |               valid_o    one-cycle strobe when count_o updates       |
// +----------------------------------------------------------------------+
module pfm_edge_counter #(
   parameter int WIN_W = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic [WIN_W-1:0] window_i,
   input  logic             pfm_i,
   output logic [CNT_W-1:0] count_o,
   output logic             valid_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             sync_1;
   logic             sync_2;
   logic             sync_3;
   logic             pfm_rise;
   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] edge_cnt_inc;
   logic             win_last;

   // Synchronizer and edge-history flop run regardless of enable so the
   // first RUN cycle already sees a settled input.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         sync_3 <= 1'b0;
      end else begin
         sync_1 <= pfm_i;
         sync_2 <= sync_1;
         sync_3 <= sync_2;
      end
   end

   assign pfm_rise = sync_2 & ~sync_3;

   // Saturating increment including an edge seen in the current cycle.
   assign edge_cnt_inc = (pfm_rise && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;

   // A window of 0 or 1 closes every cycle.
   assign win_last = (window_i <= WIN_W'(1)) || (win_cnt == window_i - WIN_W'(1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         win_cnt  <= '0;
         edge_cnt <= '0;
         count_o  <= '0;
         valid_o  <= 1'b0;
      end else if (!enable_i) begin
         win_cnt  <= '0;
         edge_cnt <= '0;
         valid_o  <= 1'b0;
      end else if (win_last) begin
         win_cnt  <= '0;
         edge_cnt <= '0;
         count_o  <= edge_cnt_inc;
         valid_o  <= 1'b1;
      end else begin
         win_cnt  <= win_cnt + WIN_W'(1);
         edge_cnt <= edge_cnt_inc;
         valid_o  <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dcdc_pad_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dcdc_pad_sequencer                                     |
// | Description : Power-up/power-down sequencer for the on-die DC-DC     |
// |               converter test pads. Generates the external converter  |
// |               clock, SM step pulses and measures PFM pulse density.  |
// | Revision    : 1.0  initial release                                   |
// |                                                                      |
// | Ports       : clk_i, rst_i           clock, sync active-high reset   |
// |               start_i, stop_i        power-up / power-down requests  |
// |               clk_div_i .. pfm_window_i  configuration, latched on   |
// |                                      the OFF->CONFIG transition      |
// |               sm_step_i              request one SM_ext pulse        |
// |               pfm_i                  asynchronous PFM_out from pad   |
// |               dcdc_*_o               pad-side converter controls     |
// |               state_o, busy_o        FSM status                      |
// |               pfm_count_o/valid_o    PFM window result and strobe    |
// +----------------------------------------------------------------------+
module dcdc_pad_sequencer
   import dcdc_seq_pkg::*;
#(
   parameter int DIV_W    = 8,
   parameter int SETTLE_W = 16,
   parameter int WIN_W    = 16,
   parameter int CNT_W    = 16,
   parameter int SM_PULSE = SM_PULSE_DEFAULT
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                stop_i,
   input  logic [DIV_W-1:0]    clk_div_i,
   input  logic [SETTLE_W-1:0] settle_i,
   input  logic                ext_clk_sel_i,
   input  logic                ext_sm_sel_i,
   input  logic                mode_i,
   input  logic                sm_step_i,
   input  logic [WIN_W-1:0]    pfm_window_i,
   input  logic                pfm_i,
   output logic                dcdc_control_1_o,
   output logic                dcdc_control_2_o,
   output logic                dcdc_clk_ext_o,
   output logic                dcdc_sel_clk_o,
   output logic                dcdc_SM_ext_o,
   output logic                dcdc_sel_SM_o,
   output logic [2:0]          state_o,
   output logic                busy_o,
   output logic [CNT_W-1:0]    pfm_count_o,
   output logic                pfm_valid_o
);

   localparam int              SM_W    = $clog2(SM_PULSE + 1);
   localparam logic [SM_W-1:0] SM_LOAD = SM_W'(SM_PULSE);

   state_e              state;
   state_e              state_nxt;

   // Latched configuration
   logic [DIV_W-1:0]    div_q;
   logic [SETTLE_W-1:0] settle_q;
   logic                ext_clk_q;
   logic                ext_sm_q;
   logic                mode_q;
   logic [WIN_W-1:0]    window_q;

   logic [SETTLE_W-1:0] settle_cnt;
   logic                phase_done;
   logic                power_up;

   logic [DIV_W-1:0]    div_cnt;
   logic                clk_ext;
   logic                clk_run;

   logic [SM_W-1:0]     sm_cnt;

   assign phase_done = (settle_cnt == '0);
   assign power_up   = (state == ST_OFF) && (state_nxt == ST_CONFIG);

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_OFF;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next state and state-decoded outputs. stop_i is checked before the
   // settle expiry so an abort always wins.
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt        = state;
      dcdc_control_1_o = 1'b0;
      dcdc_control_2_o = 1'b0;
      dcdc_sel_clk_o   = 1'b0;
      dcdc_sel_SM_o    = 1'b0;
      busy_o           = 1'b0;

      case (state)
         ST_OFF: begin
            if (start_i && !stop_i) state_nxt = ST_CONFIG;
         end
         ST_CONFIG: begin
            if (stop_i)          state_nxt = ST_SHUTDOWN;
            else if (phase_done) state_nxt = ST_CLK_START;
         end
         ST_CLK_START: begin
            if (stop_i)          state_nxt = ST_SHUTDOWN;
            else if (phase_done) state_nxt = ST_ENABLE;
         end
         ST_ENABLE: begin
            if (stop_i)          state_nxt = ST_SHUTDOWN;
            else if (phase_done) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (stop_i)          state_nxt = ST_SHUTDOWN;
         end
         ST_SHUTDOWN: begin
            if (phase_done)      state_nxt = ST_OFF;
         end
         default: begin
            state_nxt = ST_OFF;
         end
      endcase

      if (state != ST_OFF) begin
         busy_o           = 1'b1;
         dcdc_sel_clk_o   = ext_clk_q;
         dcdc_sel_SM_o    = ext_sm_q;
         dcdc_control_2_o = mode_q;
      end
      if ((state == ST_ENABLE) || (state == ST_RUN)) begin
         dcdc_control_1_o = 1'b1;
      end
   end

   assign state_o = state;

   // ------------------------------------------------------------------
   // Configuration latch: captured only when leaving OFF.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q     <= '0;
         settle_q  <= '0;
         ext_clk_q <= 1'b0;
         ext_sm_q  <= 1'b0;
         mode_q    <= 1'b0;
         window_q  <= '0;
      end else if (power_up) begin
         div_q     <= clk_div_i;
         settle_q  <= settle_i;
         ext_clk_q <= ext_clk_sel_i;
         ext_sm_q  <= ext_sm_sel_i;
         mode_q    <= mode_i;
         window_q  <= pfm_window_i;
      end
   end

   // ------------------------------------------------------------------
   // Settle counter: reloaded on every phase change, phase ends when it
   // reads zero, so a load of N gives N+1 cycles. The CONFIG load uses
   // the input directly since the latch updates on the same edge.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         settle_cnt <= '0;
      end else if (power_up) begin
         settle_cnt <= settle_i;
      end else if (state_nxt != state) begin
         settle_cnt <= settle_q;
      end else if (!phase_done) begin
         settle_cnt <= settle_cnt - SETTLE_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // External clock divider. clk_run marks that CLK_START was reached,
   // so an abort from CONFIG never starts the clock during SHUTDOWN.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clk_ext <= 1'b0;
         div_cnt <= '0;
         clk_run <= 1'b0;
      end else if ((state_nxt == ST_OFF) || (state_nxt == ST_CONFIG)) begin
         clk_ext <= 1'b0;
         div_cnt <= '0;
         clk_run <= 1'b0;
      end else if ((state != ST_CLK_START) && (state_nxt == ST_CLK_START)) begin
         clk_ext <= 1'b0;
         div_cnt <= '0;
         clk_run <= 1'b1;
      end else if (clk_run && ext_clk_q) begin
         if (div_cnt == div_q) begin
            clk_ext <= ~clk_ext;
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   assign dcdc_clk_ext_o = clk_ext;

   // ------------------------------------------------------------------
   // SM_ext pulse generator: a non-zero count means the pulse is high.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sm_cnt <= '0;
      end else if ((state != ST_RUN) || (state_nxt != ST_RUN)) begin
         sm_cnt <= '0;
      end else if (sm_cnt != '0) begin
         sm_cnt <= sm_cnt - SM_W'(1);
      end else if (sm_step_i && ext_sm_q) begin
         sm_cnt <= SM_LOAD;
      end
   end

   assign dcdc_SM_ext_o = (sm_cnt != '0);

   // ------------------------------------------------------------------
   // PFM density monitor
   // ------------------------------------------------------------------
   pfm_edge_counter #(
      .WIN_W (WIN_W),
      .CNT_W (CNT_W)
   ) u_pfm (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .enable_i (state == ST_RUN),
      .window_i (window_q),
      .pfm_i    (pfm_i),
      .count_o  (pfm_count_o),
      .valid_o  (pfm_valid_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_dcdc_pad_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dcdc_pad_sequencer                                  |
// | Description : Directed self-checking bench for dcdc_pad_sequencer.   |
// |               A second instance with a 4-bit PFM counter shares all  |
// |               stimulus to exercise counter saturation.               |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_dcdc_pad_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        stop_i = 1'b0;
   logic [7:0]  clk_div_i = '0;
   logic [15:0] settle_i = '0;
   logic        ext_clk_sel_i = 1'b0;
   logic        ext_sm_sel_i = 1'b0;
   logic        mode_i = 1'b0;
   logic        sm_step_i = 1'b0;
   logic [15:0] pfm_window_i = '0;
   logic        pfm_i = 1'b0;

   logic        control_1, control_2, clk_ext, sel_clk, sm_ext, sel_sm, busy, valid;
   logic [2:0]  state;
   logic [15:0] count;

   logic        control_1_b, control_2_b, clk_ext_b, sel_clk_b, sm_ext_b, sel_sm_b, busy_b, valid_b;
   logic [2:0]  state_b;
   logic [3:0]  count_b;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          pfm_half = 0;

   always #5 clk_i = ~clk_i;

   dcdc_pad_sequencer dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .start_i          (start_i),
      .stop_i           (stop_i),
      .clk_div_i        (clk_div_i),
      .settle_i         (settle_i),
      .ext_clk_sel_i    (ext_clk_sel_i),
      .ext_sm_sel_i     (ext_sm_sel_i),
      .mode_i           (mode_i),
      .sm_step_i        (sm_step_i),
      .pfm_window_i     (pfm_window_i),
      .pfm_i            (pfm_i),
      .dcdc_control_1_o (control_1),
      .dcdc_control_2_o (control_2),
      .dcdc_clk_ext_o   (clk_ext),
      .dcdc_sel_clk_o   (sel_clk),
      .dcdc_SM_ext_o    (sm_ext),
      .dcdc_sel_SM_o    (sel_sm),
      .state_o          (state),
      .busy_o           (busy),
      .pfm_count_o      (count),
      .pfm_valid_o      (valid)
   );

   dcdc_pad_sequencer #(.CNT_W(4)) dut4 (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .start_i          (start_i),
      .stop_i           (stop_i),
      .clk_div_i        (clk_div_i),
      .settle_i         (settle_i),
      .ext_clk_sel_i    (ext_clk_sel_i),
      .ext_sm_sel_i     (ext_sm_sel_i),
      .mode_i           (mode_i),
      .sm_step_i        (sm_step_i),
      .pfm_window_i     (pfm_window_i),
      .pfm_i            (pfm_i),
      .dcdc_control_1_o (control_1_b),
      .dcdc_control_2_o (control_2_b),
      .dcdc_clk_ext_o   (clk_ext_b),
      .dcdc_sel_clk_o   (sel_clk_b),
      .dcdc_SM_ext_o    (sm_ext_b),
      .dcdc_sel_SM_o    (sel_sm_b),
      .state_o          (state_b),
      .busy_o           (busy_b),
      .pfm_count_o      (count_b),
      .pfm_valid_o      (valid_b)
   );

   // PFM square wave: toggles every pfm_half cycles, held low when 0.
   initial begin
      int c;
      c = 0;
      forever begin
         @(posedge clk_i);
         #2;
         if (pfm_half == 0) begin
            pfm_i = 1'b0;
            c     = 0;
         end else begin
            c = c + 1;
            if (c >= pfm_half) begin
               pfm_i = ~pfm_i;
               c     = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pads();
      return {control_1, control_2, clk_ext, sel_clk, sm_ext, sel_sm, busy, valid};
   endfunction

   initial begin
      int         n;
      logic [3:0] pat4;
      logic [5:0] pat6;

      pfm_half = 5;
      // ---------------- reset ----------------
      step(); step(); step();
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_pads", 32'(pads()), 32'd0);
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_count4", 32'(count_b), 32'd0);
      rst_i = 1'b0;

      // ---------------- power-up sequence ----------------
      settle_i = 16'd3; clk_div_i = 8'd1; ext_clk_sel_i = 1'b1;
      ext_sm_sel_i = 1'b1; mode_i = 1'b1; pfm_window_i = 16'd100;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("config_entry_state", 32'(state), 32'd1);
      chk("config_entry_sel", 32'({sel_clk, sel_sm, control_2, control_1}), 32'b1110);
      n = 0;
      while (state === 3'd1 && n < 20) begin n++; step(); end
      chk("config_len", 32'(n), 32'd4);
      n = 0; pat4 = '0;
      while (state === 3'd2 && n < 20) begin pat4 = {pat4[2:0], clk_ext}; n++; step(); end
      chk("clk_start_len", 32'(n), 32'd4);
      chk("clk_ext_pattern", 32'(pat4), 32'b0011);
      chk("enable_control_1", 32'({state, control_1, clk_ext}), 32'b011_1_0);
      mode_i = 1'b0;   // must be ignored while not in OFF
      n = 0;
      while (state === 3'd3 && n < 20) begin n++; step(); end
      chk("enable_len", 32'(n), 32'd4);
      chk("run_entry", 32'({state, busy, control_1, control_2}), 32'b100_1_1_1);

      // ---------------- SM stepping (requests at t and t+2) ----------------
      sm_step_i = 1'b1;
      pat6 = '0;
      for (int i = 0; i < 6; i++) begin
         step();
         pat6 = {pat6[4:0], sm_ext};
         sm_step_i = (i == 1);
      end
      sm_step_i = 1'b0;
      chk("sm_pulse", 32'(pat6), 32'b111100);

      // ---------------- PFM measurement, period 10 ----------------
      n = 0;
      while (valid !== 1'b1 && n < 300) begin n++; step(); end
      chk("pfm_first_valid", 32'(valid), 32'd1);
      chk("pfm_count_p10", 32'(count), 32'd10);
      chk("pfm_count4_p10", 32'(count_b), 32'd10);
      step();
      chk("pfm_valid_one_cycle", 32'(valid), 32'd0);
      n = 1;
      while (valid !== 1'b1 && n < 300) begin n++; step(); end
      chk("pfm_window_spacing", 32'(n), 32'd100);
      chk("pfm_count_p10_b", 32'(count), 32'd10);

      // ---------------- saturation, period 4 ----------------
      pfm_half = 2;
      step();
      n = 0;
      while (valid !== 1'b1 && n < 300) begin n++; step(); end
      step();
      n = 0;
      while (valid !== 1'b1 && n < 300) begin n++; step(); end
      chk("pfm_count_p4", 32'(count), 32'd25);
      chk("pfm_count4_saturated", 32'(count_b), 32'd15);

      // ---------------- stop mid-window ----------------
      for (int i = 0; i < 30; i++) step();
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      chk("stop_to_shutdown", 32'({state, control_1}), 32'b101_0);
      n = 0;
      for (int i = 0; i < 150; i++) begin
         if (valid === 1'b1) n++;
         step();
      end
      chk("stop_no_strobe", 32'(n), 32'd0);
      chk("stop_count_held", 32'(count), 32'd25);
      chk("stop_off_pads", 32'({state, pads()}), 32'd0);

      // ---------------- early stop during CLK_START ----------------
      pfm_half = 0;
      settle_i = 16'd10;
      start_i  = 1'b1;
      step();
      start_i  = 1'b0;
      n = 0;
      while (state !== 3'd2 && n < 40) begin n++; step(); end
      chk("early_reach_clk_start", 32'(state), 32'd2);
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      chk("early_shutdown", 32'({state, control_1}), 32'b101_0);
      n = 0;
      while (state === 3'd5 && n < 40) begin
         if (control_1 !== 1'b0) n = n + 100;
         n++;
         step();
      end
      chk("early_shutdown_len", 32'(n), 32'd11);
      chk("early_off_pads", 32'({state, pads()}), 32'd0);

      // ---------------- settle=0 and sel_SM=0 ----------------
      settle_i = 16'd0; ext_sm_sel_i = 1'b0;
      start_i  = 1'b1;
      step();
      start_i  = 1'b0;
      step(); step(); step();
      chk("settle0_run", 32'(state), 32'd4);
      ext_sm_sel_i = 1'b1;   // must be ignored
      sm_step_i = 1'b1;
      pat6 = '0;
      for (int i = 0; i < 6; i++) begin
         step();
         sm_step_i = 1'b0;
         pat6 = {pat6[4:0], sm_ext};
      end
      chk("sm_disabled", 32'({pat6, sel_sm}), 32'd0);

      // ---------------- reset in RUN, then start/stop collision ----------------
      rst_i = 1'b1;
      step();
      chk("rst_in_run", 32'({state, pads()}), 32'd0);
      chk("rst_in_run_count", 32'(count), 32'd0);
      rst_i = 1'b0;
      start_i = 1'b1; stop_i = 1'b1;
      step(); step(); step();
      chk("start_stop_collision", 32'({state, busy}), 32'd0);
      start_i = 1'b0; stop_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
